// File: rtl/kws_pkg.sv
// ---------------------------------------------------------------------------
// kws_pkg
// Shared definitions for the keyword-spotting frame scheduler:
//   - default frame width, window depth and hop length
//   - scheduler state encoding
// ---------------------------------------------------------------------------
package kws_pkg;

    localparam int FRAME_W_DEF    = 47;
    localparam int WIN_FRAMES_DEF = 10;
    localparam int HOP_FRAMES_DEF = 2;

    typedef enum logic [1:0] {
        ST_FILL     = 2'd0,
        ST_WAIT_HOP = 2'd1,
        ST_RUN      = 2'd2
    } kws_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/kws_win_shift.sv
// ---------------------------------------------------------------------------
// kws_win_shift
// WIN_FRAMES-deep shift register of feature frames. The oldest frame lives
// in win[FRAME_W-1:0]; each shift_en cycle pushes din in as the newest frame
// at the top and discards the oldest.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset, clears the window
//   shift_en  push din this cycle
//   din       incoming frame
//   win       current window, oldest frame in the low bits
// ---------------------------------------------------------------------------
module kws_win_shift #(
    parameter int FRAME_W    = 47,
    parameter int WIN_FRAMES = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          shift_en,
    input  logic [FRAME_W-1:0]            din,
    output logic [WIN_FRAMES*FRAME_W-1:0] win
);

    localparam int WW = WIN_FRAMES * FRAME_W;

    generate
        if (WIN_FRAMES > 1) begin : g_multi
            always_ff @(posedge clk) begin
                if (rst) begin
                    win <= '0;
                end else if (shift_en) begin
                    win <= {din, win[WW-1:FRAME_W]};
                end
            end
        end else begin : g_single
            always_ff @(posedge clk) begin
                if (rst) begin
                    win <= '0;
                end else if (shift_en) begin
                    win <= din;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/kws_frame_scheduler.sv
// ---------------------------------------------------------------------------
// kws_frame_scheduler
// Collects mel feature frames into a sliding window and launches the keyword
// classifier every HOP_FRAMES new frames. Frames are never dropped; if a hop
// completes while the classifier is still busy the launch is held pending
// and issued as soon as the classifier finishes.
//
// Optional feature: define KWS_SCHED_DROP_CNT_EN to add the drop_cnt port,
// a saturating count of hops that completed while a launch was already
// pending (i.e. launches that were skipped).
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   feat_in     mel frame, valid when feat_valid is high (no backpressure)
//   feat_valid  frame strobe
//   dnn_win     window snapshot for the classifier, oldest frame in low bits
//   dnn_start   one-cycle classifier launch pulse
//   dnn_done    classifier result strobe (only honoured while busy)
//   dnn_result  classifier class index
//   kws_out     last keyword result, held between pulses
//   kws_valid   one-cycle pulse qualifying kws_out
//   busy        classifier running
//   drop_cnt    skipped launches, saturating (KWS_SCHED_DROP_CNT_EN only)
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_FILL     | after reset, waiting for the first full window
// ST_WAIT_HOP | classifier idle, counting frames toward the next hop
// ST_RUN      | classifier busy; hops completing now set pending
// ---------------------------------------------------------------------------
module kws_frame_scheduler
    import kws_pkg::*;
#(
    parameter int FRAME_W    = FRAME_W_DEF,
    parameter int WIN_FRAMES = WIN_FRAMES_DEF,
    parameter int HOP_FRAMES = HOP_FRAMES_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [FRAME_W-1:0]            feat_in,
    input  logic                          feat_valid,
    output logic [WIN_FRAMES*FRAME_W-1:0] dnn_win,
    output logic                          dnn_start,
    input  logic                          dnn_done,
    input  logic [3:0]                    dnn_result,
    output logic [3:0]                    kws_out,
    output logic                          kws_valid,
    output logic                          busy
`ifdef KWS_SCHED_DROP_CNT_EN
    ,
    output logic [7:0]                    drop_cnt
`endif
);

    localparam int WW   = WIN_FRAMES * FRAME_W;
    localparam int FC_W = cnt_width(WIN_FRAMES);
    localparam int HC_W = cnt_width(HOP_FRAMES);

    kws_state_e       state;
    logic [FC_W-1:0]  frame_cnt;
    logic [HC_W-1:0]  hop_cnt;
    logic             pending;
    logic [WW-1:0]    win;
    logic [WW-1:0]    win_next;
    logic             fill_done;
    logic             hop_done;

    kws_win_shift #(
        .FRAME_W    (FRAME_W),
        .WIN_FRAMES (WIN_FRAMES)
    ) u_win_shift (
        .clk      (clk),
        .rst      (rst),
        .shift_en (feat_valid),
        .din      (feat_in),
        .win      (win)
    );

    // Window as it will read after this edge, so a launch captures the frame
    // accepted in the same cycle.
    generate
        if (WIN_FRAMES > 1) begin : g_next_multi
            assign win_next = feat_valid ? {feat_in, win[WW-1:FRAME_W]} : win;
        end else begin : g_next_single
            assign win_next = feat_valid ? feat_in : win;
        end
    endgenerate

    assign fill_done = feat_valid && (frame_cnt == FC_W'(WIN_FRAMES - 1));
    assign hop_done  = feat_valid && (hop_cnt == HC_W'(HOP_FRAMES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FILL;
            frame_cnt <= '0;
            hop_cnt   <= '0;
            pending   <= 1'b0;
            dnn_win   <= '0;
            dnn_start <= 1'b0;
            kws_out   <= 4'd0;
            kws_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef KWS_SCHED_DROP_CNT_EN
            drop_cnt  <= 8'd0;
`endif
        end else begin
            dnn_start <= 1'b0;
            kws_valid <= 1'b0;

            case (state)
                ST_FILL: begin
                    if (fill_done) begin
                        frame_cnt <= '0;
                        hop_cnt   <= '0;
                        dnn_start <= 1'b1;
                        dnn_win   <= win_next;
                        busy      <= 1'b1;
                        state     <= ST_RUN;
                    end else if (feat_valid) begin
                        frame_cnt <= frame_cnt + FC_W'(1);
                    end
                end

                ST_WAIT_HOP: begin
                    if (hop_done) begin
                        hop_cnt   <= '0;
                        dnn_start <= 1'b1;
                        dnn_win   <= win_next;
                        busy      <= 1'b1;
                        state     <= ST_RUN;
                    end else if (feat_valid) begin
                        hop_cnt <= hop_cnt + HC_W'(1);
                    end
                end

                ST_RUN: begin
                    if (hop_done) begin
                        hop_cnt <= '0;
                        pending <= 1'b1;
`ifdef KWS_SCHED_DROP_CNT_EN
                        if (pending && (drop_cnt != 8'hFF)) begin
                            drop_cnt <= drop_cnt + 8'd1;
                        end
`endif
                    end else if (feat_valid) begin
                        hop_cnt <= hop_cnt + HC_W'(1);
                    end

                    if (dnn_done) begin
                        kws_out   <= dnn_result;
                        kws_valid <= 1'b1;
                        // Back-to-back launch: every launch restarts the hop
                        // count, so frames since the last launch stay meaningful.
                        if (pending || hop_done) begin
                            pending   <= 1'b0;
                            hop_cnt   <= '0;
                            dnn_start <= 1'b1;
                            dnn_win   <= win_next;
                        end else begin
                            busy  <= 1'b0;
                            state <= ST_WAIT_HOP;
                        end
                    end
                end

                default: begin
                    state <= ST_FILL;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kws_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_kws_frame_scheduler
// Directed scenarios plus randomized traffic, checked every cycle against a
// reference model that keeps the frame history as a queue and reasons in
// terms of "frames since last launch", "classifier busy" and "launch owed".
// ---------------------------------------------------------------------------
module tb_kws_frame_scheduler;

    localparam int FW  = 47;
    localparam int WIN = 10;
    localparam int HOP = 2;
    localparam int WW  = WIN * FW;

    logic           clk;
    logic           rst;
    logic [FW-1:0]  feat_in;
    logic           feat_valid;
    logic [WW-1:0]  dnn_win;
    logic           dnn_start;
    logic           dnn_done;
    logic [3:0]     dnn_result;
    logic [3:0]     kws_out;
    logic           kws_valid;
    logic           busy;
`ifdef KWS_SCHED_DROP_CNT_EN
    logic [7:0]     drop_cnt;
`endif

    kws_frame_scheduler #(
        .FRAME_W    (FW),
        .WIN_FRAMES (WIN),
        .HOP_FRAMES (HOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .feat_in    (feat_in),
        .feat_valid (feat_valid),
        .dnn_win    (dnn_win),
        .dnn_start  (dnn_start),
        .dnn_done   (dnn_done),
        .dnn_result (dnn_result),
        .kws_out    (kws_out),
        .kws_valid  (kws_valid),
        .busy       (busy)
`ifdef KWS_SCHED_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // ---------------- reference model ----------------
    logic [FW-1:0] hist[$];
    bit            m_busy;
    bit            m_primed;
    bit            m_owed;
    int            m_since;
    int            m_drop;

    logic [WW-1:0] e_win;
    logic          e_start;
    logic [3:0]    e_kws;
    logic          e_valid;

    function automatic logic [WW-1:0] pack_hist();
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < hist.size(); i++) w[i*FW +: FW] = hist[i];
        return w;
    endfunction

    task automatic model_step(input bit r, input bit fv, input logic [FW-1:0] f,
                              input bit dd, input logic [3:0] dr);
        bit launch;
        e_start = 1'b0;
        e_valid = 1'b0;
        if (r) begin
            hist.delete();
            m_busy = 0; m_primed = 0; m_owed = 0; m_since = 0; m_drop = 0;
            e_win = '0; e_kws = 4'd0;
            return;
        end
        if (fv) begin
            hist.push_back(f);
            if (hist.size() > WIN) void'(hist.pop_front());
            m_since++;
        end
        launch = 0;
        if (!m_busy) begin
            if (m_since == (m_primed ? HOP : WIN)) launch = 1;
        end else begin
            if (m_since == HOP) begin
                if (m_owed && m_drop < 255) m_drop++;
                m_owed  = 1;
                m_since = 0;
            end
            if (dd) begin
                e_valid = 1'b1;
                e_kws   = dr;
                if (m_owed) launch = 1;
                else m_busy = 0;
            end
        end
        if (launch) begin
            m_busy = 1; m_primed = 1; m_owed = 0; m_since = 0;
            e_start = 1'b1;
            e_win   = pack_hist();
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_win(input string name, input logic [WW-1:0] exp);
        n_vec++;
        if (dnn_win !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, dnn_win, exp);
        end
    endtask

    task automatic compare_all();
        chk("dnn_start", 64'(dnn_start), 64'(e_start));
        chk("kws_valid", 64'(kws_valid), 64'(e_valid));
        chk("kws_out",   64'(kws_out),   64'(e_kws));
        chk("busy",      64'(busy),      64'(m_busy));
        chk_win("dnn_win", e_win);
`ifdef KWS_SCHED_DROP_CNT_EN
        chk("drop_cnt",  64'(drop_cnt),  64'(m_drop));
`endif
    endtask

    // One clock: drive at negedge, step the model, compare just after posedge.
    task automatic cyc(input bit r, input bit fv, input logic [FW-1:0] f,
                       input bit dd, input logic [3:0] dr);
        @(negedge clk);
        rst = r; feat_valid = fv; feat_in = f; dnn_done = dd; dnn_result = dr;
        model_step(r, fv, f, dd, dr);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    int k = 0;
    task automatic frame(input bit dd, input logic [3:0] dr);
        cyc(1'b0, 1'b1, FW'(k), dd, dr);
        k++;
    endtask

    task automatic idle(input bit dd, input logic [3:0] dr);
        cyc(1'b0, 1'b0, '0, dd, dr);
    endtask

    initial begin
        rst = 1'b1; feat_valid = 1'b0; feat_in = '0; dnn_done = 1'b0; dnn_result = 4'd0;
        e_win = '0; e_start = 0; e_kws = 0; e_valid = 0;
        m_busy = 0; m_primed = 0; m_owed = 0; m_since = 0; m_drop = 0;

        // reset
        cyc(1'b1, 1'b0, '0, 1'b0, 4'd0);
        cyc(1'b1, 1'b1, FW'(55), 1'b1, 4'd9);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_win_low", 64'(dnn_win[FW-1:0]), 64'd0);

        // first window: 9 frames no launch, 10th launches
        k = 0;
        for (int i = 0; i < 9; i++) frame(1'b0, 4'd0);
        chk("no_start_9", 64'(dnn_start), 64'd0);
        frame(1'b0, 4'd0);
        chk("first_start", 64'(dnn_start), 64'd1);
        chk("first_oldest", 64'(dnn_win[FW-1:0]), 64'd0);
        chk("first_newest", 64'(dnn_win[9*FW +: FW]), 64'd9);
        chk("first_busy", 64'(busy), 64'd1);

        // result, then a hop of two frames
        idle(1'b1, 4'h7);
        chk("kws7_out", 64'(kws_out), 64'd7);
        chk("kws7_valid", 64'(kws_valid), 64'd1);
        idle(1'b0, 4'h0);
        chk("kws7_hold", 64'(kws_out), 64'd7);
        frame(1'b0, 4'd0);
        frame(1'b0, 4'd0);
        chk("hop_start", 64'(dnn_start), 64'd1);
        chk("hop_oldest", 64'(dnn_win[FW-1:0]), 64'd2);

        // withhold done across two hops: one skipped launch
        for (int i = 0; i < 4; i++) frame(1'b0, 4'd0);
`ifdef KWS_SCHED_DROP_CNT_EN
        chk("drop_one", 64'(drop_cnt), 64'd1);
`endif
        idle(1'b1, 4'h3);
        chk("pend_start", 64'(dnn_start), 64'd1);
        chk("pend_oldest", 64'(dnn_win[FW-1:0]), 64'd6);
        chk("pend_newest", 64'(dnn_win[9*FW +: FW]), 64'd15);

        // hop completes in same cycle as done
        frame(1'b0, 4'd0);
        frame(1'b1, 4'h5);
        chk("same_valid", 64'(kws_valid), 64'd1);
        chk("same_start", 64'(dnn_start), 64'd1);
        chk("same_oldest", 64'(dnn_win[FW-1:0]), 64'd8);

        // reset while running
        cyc(1'b1, 1'b0, '0, 1'b0, 4'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_kws", 64'(kws_out), 64'd0);
        idle(1'b1, 4'hA);
        chk("midrst_nodone", 64'(kws_valid), 64'd0);
        for (int i = 0; i < 9; i++) frame(1'b1, 4'd1);
        chk("midrst_no_start", 64'(dnn_start), 64'd0);
        frame(1'b0, 4'd0);
        chk("midrst_start", 64'(dnn_start), 64'd1);

        // long overrun: 620 frames => 310 hops while busy
        for (int i = 0; i < 620; i++) frame(1'b0, 4'd0);
`ifdef KWS_SCHED_DROP_CNT_EN
        chk("drop_sat", 64'(drop_cnt), 64'd255);
`endif
        idle(1'b1, 4'h2);
        chk("sat_start", 64'(dnn_start), 64'd1);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit            r, fv, dd;
            logic [FW-1:0] f;
            logic [3:0]    dr;
            r  = ($urandom_range(0, 249) == 0);
            fv = ($urandom_range(0, 1) == 1);
            dd = ($urandom_range(0, 4) == 0);
            f  = FW'({$urandom(), $urandom()});
            dr = 4'($urandom_range(0, 15));
            cyc(r, fv, f, dd, dr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
